// File: rtl/adc_capture_ctrl.sv
// AD9280-class ADC front end: programmable sample clock, pipeline-latency flush
// and block reduction (pass / boxcar average / max / min) with a clip flag.
module adc_capture_ctrl #(
  parameter int DATA_W       = 8,
  parameter int DIV_W        = 8,
  parameter int AVG_MAX_LOG2 = 4,
  parameter int PIPE_LAT     = 3
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [1:0]        mode,
  input  logic [2:0]        avg_log2,
  input  logic [DATA_W-1:0] ad_data,
  output logic              ad_clk,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              ovr
);
  localparam int ACC_W      = DATA_W + AVG_MAX_LOG2;
  localparam int BLK_W      = (AVG_MAX_LOG2 > 0) ? AVG_MAX_LOG2 : 1;
  localparam int FL_W       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int FLUSH_LAST = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
  localparam logic [2:0] K_MAX = 3'(AVG_MAX_LOG2);

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, RUN = 2'd2} state_t;

  state_t            state_r, state_s;
  logic [DIV_W-1:0]  clk_div_r, div_cnt_r;
  logic [1:0]        mode_r;
  logic [2:0]        k_r, k_clamp_s;
  logic              cap_r, s_stb_r;
  logic [DATA_W-1:0] s_q_r, max_r, min_r, max_s, min_s, result_s;
  logic [FL_W-1:0]   flush_cnt_r;
  logic [BLK_W-1:0]  blk_cnt_r, last_idx_s;
  logic [ACC_W-1:0]  acc_r, acc_s;
  logic              clip_r, clip_blk_s, first_s, last_s;

  function automatic logic is_clipped(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b0}}) || (v == {DATA_W{1'b1}});
  endfunction

  // Block size exponent to latch: clamped, and forced to 0 in pass mode
  always_comb begin
    k_clamp_s = avg_log2;
    if (mode == 2'd0) begin
      k_clamp_s = 3'd0;
    end else if (avg_log2 > K_MAX) begin
      k_clamp_s = K_MAX;
    end else begin
      k_clamp_s = avg_log2;
    end
  end

  // Configuration is sampled only on the start edge out of IDLE
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_div_r <= {DIV_W{1'b0}};
      mode_r    <= 2'd0;
      k_r       <= 3'd0;
    end else if (state_r == IDLE && enable) begin
      clk_div_r <= clk_div;
      mode_r    <= mode;
      k_r       <= k_clamp_s;
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // FSM next state; an enable drop always wins
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_s = (PIPE_LAT == 0) ? RUN : FLUSH;
        else        state_s = IDLE;
      end
      FLUSH: begin
        if (!enable)                                          state_s = IDLE;
        else if (s_stb_r && flush_cnt_r == FL_W'(FLUSH_LAST)) state_s = RUN;
        else                                                  state_s = FLUSH;
      end
      RUN: begin
        if (!enable) state_s = IDLE;
        else         state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Sample clock divider; the rising toggle captures ad_data, s_stb follows one cycle later
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      ad_clk    <= 1'b0;
      cap_r     <= 1'b0;
      s_stb_r   <= 1'b0;
      s_q_r     <= {DATA_W{1'b0}};
    end else if (state_r == IDLE || !enable) begin
      div_cnt_r <= {DIV_W{1'b0}};
      ad_clk    <= 1'b0;
      cap_r     <= 1'b0;
      s_stb_r   <= 1'b0;
    end else begin
      s_stb_r <= cap_r;
      if (div_cnt_r == clk_div_r) begin
        div_cnt_r <= {DIV_W{1'b0}};
        ad_clk    <= ~ad_clk;
        cap_r     <= ~ad_clk;
        if (!ad_clk) s_q_r <= ad_data;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
        cap_r     <= 1'b0;
      end
    end
  end

  // Discarded-sample counter for the converter pipeline flush
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_r <= {FL_W{1'b0}};
    end else if (state_r != FLUSH || !enable) begin
      flush_cnt_r <= {FL_W{1'b0}};
    end else if (s_stb_r) begin
      if (flush_cnt_r == FL_W'(FLUSH_LAST)) flush_cnt_r <= {FL_W{1'b0}};
      else                                  flush_cnt_r <= flush_cnt_r + FL_W'(1);
    end
  end

  // Reducer next values and the per-mode block result
  always_comb begin
    last_idx_s = {BLK_W{1'b0}};
    for (int i = 0; i < BLK_W; i++) last_idx_s[i] = (i < int'(k_r));
    first_s = (blk_cnt_r == {BLK_W{1'b0}});
    last_s  = (blk_cnt_r == last_idx_s);
    if (first_s) begin
      acc_s      = ACC_W'(s_q_r);
      max_s      = s_q_r;
      min_s      = s_q_r;
      clip_blk_s = is_clipped(s_q_r);
    end else begin
      acc_s      = acc_r + ACC_W'(s_q_r);
      max_s      = (s_q_r > max_r) ? s_q_r : max_r;
      min_s      = (s_q_r < min_r) ? s_q_r : min_r;
      clip_blk_s = clip_r | is_clipped(s_q_r);
    end
    case (mode_r)
      2'd0:    result_s = s_q_r;
      2'd1:    result_s = DATA_W'(acc_s >> k_r);
      2'd2:    result_s = max_s;
      2'd3:    result_s = min_s;
      default: result_s = s_q_r;
    endcase
  end

  // Block accumulation and registered outputs; a partial block is dropped on abort
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_r  <= {BLK_W{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      max_r      <= {DATA_W{1'b0}};
      min_r      <= {DATA_W{1'b0}};
      clip_r     <= 1'b0;
      data_out   <= {DATA_W{1'b0}};
      ovr        <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state_r != RUN || !enable) begin
        blk_cnt_r <= {BLK_W{1'b0}};
      end else if (s_stb_r) begin
        acc_r  <= acc_s;
        max_r  <= max_s;
        min_r  <= min_s;
        clip_r <= clip_blk_s;
        if (last_s) begin
          blk_cnt_r  <= {BLK_W{1'b0}};
          data_out   <= result_s;
          ovr        <= clip_blk_s;
          data_valid <= 1'b1;
        end else begin
          blk_cnt_r <= blk_cnt_r + BLK_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: every expectation is a hand-derived
// cycle/value relative to the start edge T0 (first edge that sees enable=1).
module tb_adc_capture_ctrl;
  localparam int DATA_W = 8, DIV_W = 8, AVG_MAX_LOG2 = 4, PIPE_LAT = 3;

  logic              sys_clk  = 1'b0;
  logic              rst_n    = 1'b0;
  logic              enable   = 1'b0;
  logic [DIV_W-1:0]  clk_div  = 8'd0;
  logic [1:0]        mode     = 2'd0;
  logic [2:0]        avg_log2 = 3'd0;
  logic [DATA_W-1:0] ad_data  = 8'd0;
  logic              ad_clk, data_valid, ovr;
  logic [DATA_W-1:0] data_out;
  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  adc_capture_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W), .AVG_MAX_LOG2(AVG_MAX_LOG2),
                     .PIPE_LAT(PIPE_LAT)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .clk_div(clk_div),
    .mode(mode), .avg_log2(avg_log2), .ad_data(ad_data), .ad_clk(ad_clk),
    .data_out(data_out), .data_valid(data_valid), .ovr(ovr));

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic go_idle();
    enable = 1'b0;
    step();
    step();
  endtask

  // Called just after an edge; the following edge is T0
  task automatic start(input logic [7:0] cd, input logic [1:0] md, input logic [2:0] al);
    clk_div = cd; mode = md; avg_log2 = al; enable = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({ad_clk, data_valid, ovr, data_out} !== 11'd0) begin
      n_err++; $display("FAIL reset_init: got %b, expected all zero", {ad_clk, data_valid, ovr, data_out});
    end
    step(); rst_n = 1'b1; step();
    start(8'd0, 2'd0, 3'd0);
    for (int j = 0; j < 12; j++) begin ad_data = 8'(100 + j); step(); end
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'd109 || ad_clk !== 1'b1) begin
      n_err++; $display("FAIL pre_reset: got v=%b d=%0d clk=%b, expected v=1 d=109 clk=1", data_valid, data_out, ad_clk);
    end
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({ad_clk, data_valid, ovr, data_out} !== 11'd0) begin
      n_err++; $display("FAIL reset_async: got %b, expected all zero", {ad_clk, data_valid, ovr, data_out});
    end
    step(); rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      ad_data = 8'(100 + j); step();
      n_cmp++;
      if (data_valid !== (j == 9)) begin
        n_err++; $display("FAIL reset_restart j=%0d: got %b, expected %b", j, data_valid, (j == 9));
      end
    end
    go_idle();
  endtask

  task automatic test_pass();
    logic       exp_v;
    logic [7:0] exp_d;
    start(8'd0, 2'd0, 3'd5);
    for (int j = 0; j < 24; j++) begin
      ad_data = 8'(240 + j); step();
      exp_v = (j >= 9) && (j % 2 == 1);
      exp_d = 8'(240 + j - 2);
      n_cmp++;
      if (ad_clk !== (j % 2 == 1)) begin
        n_err++; $display("FAIL pass_adclk j=%0d: got %b, expected %b", j, ad_clk, (j % 2 == 1));
      end
      n_cmp++;
      if (data_valid !== exp_v) begin
        n_err++; $display("FAIL pass_valid j=%0d: got %b, expected %b", j, data_valid, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (data_out !== exp_d || ovr !== (exp_d == 8'hFF || exp_d == 8'h00)) begin
          n_err++; $display("FAIL pass_data j=%0d: got %0d ovr=%b, expected %0d", j, data_out, ovr, exp_d);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_average();
    logic [7:0] tbl [12];
    tbl = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'd10, 8'd11, 8'd12, 8'd14, 8'd20, 8'd20, 8'd21, 8'd22};
    start(8'd0, 2'd1, 3'd2);
    for (int j = 0; j < 25; j++) begin
      ad_data = (j % 2 == 1 && (j + 1) / 2 <= 11) ? tbl[(j + 1) / 2] : 8'h00;
      step();
      n_cmp++;
      if (data_valid !== (j == 15 || j == 23)) begin
        n_err++; $display("FAIL avg_valid j=%0d: got %b, expected %b", j, data_valid, (j == 15 || j == 23));
      end
      if (j == 15 || j == 19) begin
        n_cmp++;
        if (data_out !== 8'd11 || ovr !== 1'b0) begin
          n_err++; $display("FAIL avg_blk0 j=%0d: got %0d ovr=%b, expected 11 ovr=0", j, data_out, ovr);
        end
      end
      if (j == 23) begin
        n_cmp++;
        if (data_out !== 8'd20 || ovr !== 1'b0) begin
          n_err++; $display("FAIL avg_blk1: got %0d ovr=%b, expected 20 ovr=0", data_out, ovr);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_maxmin();
    logic [7:0] tbl [12];
    logic [7:0] e_d0, e_d1;
    logic       e_o0, e_o1;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 0) begin
        tbl = '{8'h00, 8'd1, 8'd2, 8'd3, 8'd5, 8'hFF, 8'd7, 8'd9, 8'd3, 8'd4, 8'd5, 8'd6};
        e_d0 = 8'hFF; e_o0 = 1'b1; e_d1 = 8'd6; e_o1 = 1'b0;
        start(8'd0, 2'd2, 3'd2);
      end else begin
        tbl = '{8'h00, 8'd1, 8'd2, 8'd3, 8'd0, 8'd8, 8'd9, 8'd10, 8'd9, 8'd7, 8'd200, 8'd8};
        e_d0 = 8'd0; e_o0 = 1'b1; e_d1 = 8'd7; e_o1 = 1'b0;
        start(8'd0, 2'd3, 3'd2);
      end
      for (int j = 0; j < 24; j++) begin
        ad_data = (j % 2 == 1 && (j + 1) / 2 <= 11) ? tbl[(j + 1) / 2] : 8'h00;
        step();
        n_cmp++;
        if (data_valid !== (j == 15 || j == 23)) begin
          n_err++; $display("FAIL mm_valid ph=%0d j=%0d: got %b", ph, j, data_valid);
        end
        if (j == 15) begin
          n_cmp++;
          if (data_out !== e_d0 || ovr !== e_o0) begin
            n_err++; $display("FAIL mm_blk0 ph=%0d: got %0d ovr=%b, expected %0d ovr=%b", ph, data_out, ovr, e_d0, e_o0);
          end
        end
        if (j == 23) begin
          n_cmp++;
          if (data_out !== e_d1 || ovr !== e_o1) begin
            n_err++; $display("FAIL mm_blk1 ph=%0d: got %0d ovr=%b, expected %0d ovr=%b", ph, data_out, ovr, e_d1, e_o1);
          end
        end
      end
      go_idle();
    end
  endtask

  task automatic test_divider();
    logic exp_c, exp_v;
    start(8'd3, 2'd0, 3'd2);
    for (int j = 0; j < 41; j++) begin
      if (j == 10) begin clk_div = 8'd0; mode = 2'd1; end
      ad_data = 8'(40 + j); step();
      exp_c = (j >= 4) && (((j - 4) / 4) % 2 == 0);
      exp_v = (j >= 30) && ((j - 30) % 8 == 0);
      n_cmp++;
      if (ad_clk !== exp_c) begin
        n_err++; $display("FAIL div_adclk j=%0d: got %b, expected %b", j, ad_clk, exp_c);
      end
      n_cmp++;
      if (data_valid !== exp_v) begin
        n_err++; $display("FAIL div_valid j=%0d: got %b, expected %b", j, data_valid, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (data_out !== 8'(40 + j - 2)) begin
          n_err++; $display("FAIL div_data j=%0d: got %0d, expected %0d", j, data_out, 8'(40 + j - 2));
        end
      end
    end
    go_idle();
    start(8'd0, 2'd1, 3'd2);
    ad_data = 8'd50;
    for (int j = 0; j < 16; j++) begin
      step();
      if (j == 1 || j == 2) begin
        n_cmp++;
        if (ad_clk !== (j == 1)) begin
          n_err++; $display("FAIL relatch_adclk j=%0d: got %b, expected %b", j, ad_clk, (j == 1));
        end
      end
      n_cmp++;
      if (data_valid !== (j == 15)) begin
        n_err++; $display("FAIL relatch_valid j=%0d: got %b, expected %b", j, data_valid, (j == 15));
      end
    end
    n_cmp++;
    if (data_out !== 8'd50) begin
      n_err++; $display("FAIL relatch_data: got %0d, expected 50", data_out);
    end
    go_idle();
  endtask

  task automatic test_abort();
    start(8'd0, 2'd1, 3'd2);
    for (int j = 0; j < 15; j++) begin
      if (j == 11) enable = 1'b0;
      ad_data = (j % 2 == 1) ? 8'(((j + 1) / 2) * 3) : 8'h00;
      step();
      n_cmp++;
      if (data_valid !== 1'b0) begin
        n_err++; $display("FAIL abort_valid j=%0d: got %b, expected 0", j, data_valid);
      end
      if (j == 11) begin
        n_cmp++;
        if (ad_clk !== 1'b0) begin
          n_err++; $display("FAIL abort_adclk: got %b, expected 0", ad_clk);
        end
      end
    end
    start(8'd0, 2'd1, 3'd7);
    for (int j = 0; j < 73; j++) begin
      if (j == 71) enable = 1'b0;
      ad_data = (j % 2 == 1) ? 8'(((j + 1) / 2) * 3) : 8'h00;
      step();
      n_cmp++;
      if (data_valid !== (j == 39)) begin
        n_err++; $display("FAIL clamp_valid j=%0d: got %b, expected %b", j, data_valid, (j == 39));
      end
      if (j == 39) begin
        n_cmp++;
        if (data_out !== 8'd34 || ovr !== 1'b0) begin
          n_err++; $display("FAIL clamp_data: got %0d ovr=%b, expected 34 ovr=0", data_out, ovr);
        end
      end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_average();
    test_maxmin();
    test_divider();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
